// File: rtl/mips_mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one single-ported memory bus.
// One transaction at a time, round-robin on contention, with an optional bus-hang timeout.
module mips_mem_arbiter #(
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [3:0]  m_byteenable,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        timeout_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t          state_q;
    logic            last_data_q;
    logic            grant_data_q;
    logic            is_write_q;
    logic [TO_W-1:0] cnt_q;
    logic [31:0]     m_address_q;
    logic [31:0]     m_writedata_q;
    logic [3:0]      m_byteenable_q;
    logic            m_read_q;
    logic            m_write_q;
    logic            i_ack_q;
    logic            d_ack_q;
    logic [31:0]     i_rdata_q;
    logic [31:0]     d_rdata_q;
    logic            timeout_err_q;
    logic            busy_q;

    logic d_pend;
    logic take_data;
    logic to_hit;

    // On contention the port that was not served last wins.
    assign d_pend    = d_read | d_write;
    assign take_data = d_pend & (~i_req | ~last_data_q);
    assign to_hit    = TO_EN && (cnt_q == TO_LAST);

    // Arbiter FSM with all bus-side and port-side outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            last_data_q    <= 1'b1;
            grant_data_q   <= 1'b0;
            is_write_q     <= 1'b0;
            cnt_q          <= '0;
            m_address_q    <= 32'h0;
            m_writedata_q  <= 32'h0;
            m_byteenable_q <= 4'b0000;
            m_read_q       <= 1'b0;
            m_write_q      <= 1'b0;
            i_ack_q        <= 1'b0;
            d_ack_q        <= 1'b0;
            i_rdata_q      <= 32'h0;
            d_rdata_q      <= 32'h0;
            timeout_err_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_req || d_pend) begin
                        state_q      <= S_BUS;
                        busy_q       <= 1'b1;
                        cnt_q        <= '0;
                        grant_data_q <= take_data;
                        last_data_q  <= take_data;
                        if (take_data) begin
                            m_address_q    <= d_addr;
                            m_byteenable_q <= d_byteenable;
                            m_writedata_q  <= d_wdata;
                            m_write_q      <= d_write;
                            m_read_q       <= ~d_write;
                            is_write_q     <= d_write;
                        end else begin
                            m_address_q    <= i_addr;
                            m_byteenable_q <= 4'b1111;
                            m_write_q      <= 1'b0;
                            m_read_q       <= 1'b1;
                            is_write_q     <= 1'b0;
                        end
                    end
                end
                S_BUS: begin
                    if (!m_waitrequest) begin
                        m_read_q  <= 1'b0;
                        m_write_q <= 1'b0;
                        state_q   <= S_RESP;
                        if (grant_data_q) begin
                            d_ack_q <= 1'b1;
                            if (!is_write_q) begin
                                d_rdata_q <= m_readdata;
                            end
                        end else begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= m_readdata;
                        end
                    end else if (to_hit) begin
                        // Abort a hung cycle but still ack so the core cannot deadlock.
                        m_read_q      <= 1'b0;
                        m_write_q     <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= S_RESP;
                        if (grant_data_q) begin
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= 32'h0;
                        end else begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= 32'h0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    m_read_q  <= 1'b0;
                    m_write_q <= 1'b0;
                    i_ack_q   <= 1'b0;
                    d_ack_q   <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign m_address    = m_address_q;
    assign m_writedata  = m_writedata_q;
    assign m_byteenable = m_byteenable_q;
    assign m_read       = m_read_q;
    assign m_write      = m_write_q;
    assign i_ack        = i_ack_q;
    assign d_ack        = d_ack_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign timeout_err  = timeout_err_q;
    assign busy         = busy_q;

endmodule
